// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU widths and the packed request record carried from core to FPU.
package cv32e40p_apu_core_pkg;

    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;

    typedef struct packed {
        logic [APU_NARGS_CPU*32-1:0] operands;
        logic [APU_WOP_CPU-1:0]      op;
        logic [APU_NDSFLAGS_CPU-1:0] flags;
    } apu_req_t;

endpackage

// File: rtl/cv32e40p_apu_req_fifo.sv
// DEPTH-entry request FIFO; head visible the cycle after a push (no bypass).
// Full/empty from read/write pointers carrying an extra wrap bit.
module cv32e40p_apu_req_fifo
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  apu_req_t wdata,
    output apu_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    apu_req_t    mem [DEPTH];

    // Index wraps at DEPTH-1 so non-power-of-two depths still work.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH-1))
            return {~p[AW], {AW{1'b0}}};
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cv32e40p_apu_req_buffer.sv
// Decouples core APU requests from the FPU: buffers, caps in-flight ops, registers results (1 cycle).
// Core sees gnt only while the buffer has room; results have no backpressure.
module cv32e40p_apu_req_buffer
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int REQ_DEPTH       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          apu_req_i,
    output logic                          apu_gnt_o,
    input  logic [APU_NARGS_CPU*32-1:0]   apu_operands_i,
    input  logic [APU_WOP_CPU-1:0]        apu_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]   apu_flags_i,
    output logic                          apu_rvalid_o,
    output logic [31:0]                   apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]   apu_flags_o,
    output logic                          fpu_req_o,
    input  logic                          fpu_gnt_i,
    output logic [APU_NARGS_CPU*32-1:0]   fpu_operands_o,
    output logic [APU_WOP_CPU-1:0]        fpu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]   fpu_flags_o,
    input  logic                          fpu_rvalid_i,
    input  logic [31:0]                   fpu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]   fpu_rflags_i,
    output logic                          busy_o
);

    localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          res_take;
    apu_req_t      wreq;
    apu_req_t      head;
    apu_req_t      fpu_dat;

    assign wreq = '{operands: apu_operands_i, op: apu_op_i, flags: apu_flags_i};

    cv32e40p_apu_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (wreq),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A full buffer refuses even when a pop happens this cycle.
    assign apu_gnt_o = !rst_i && !fifo_full;
    assign push      = apu_req_i && apu_gnt_o;
    assign fpu_req_o = !rst_i && !fifo_empty && (cnt < MAX_CNT);
    assign pop       = fpu_req_o && fpu_gnt_i;

    assign fpu_dat        = (!rst_i && !fifo_empty) ? head : '0;
    assign fpu_operands_o = fpu_dat.operands;
    assign fpu_op_o       = fpu_dat.op;
    assign fpu_flags_o    = fpu_dat.flags;

    // A result with nothing outstanding leaves the count at zero.
    assign res_take = fpu_rvalid_i && (cnt != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else begin
            case ({pop, res_take})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            apu_rvalid_o <= 1'b0;
            apu_result_o <= '0;
            apu_flags_o  <= '0;
        end else begin
            apu_rvalid_o <= fpu_rvalid_i;
            if (fpu_rvalid_i) begin
                apu_result_o <= fpu_rdata_i;
                apu_flags_o  <= fpu_rflags_i;
            end
        end
    end

    assign busy_o = !fifo_empty || (cnt != '0) || apu_rvalid_o;

    // Spurious FPU result: forwarded anyway, but flagged (expected after a mid-op reset).
    spurious_result: cover property (@(posedge clk_i) disable iff (rst_i)
        fpu_rvalid_i && (cnt == '0));

endmodule

// File: tb/tb_cv32e40p_apu_req_buffer.sv
// Directed and scoreboard-checked stimulus for the APU request buffer.
module tb_cv32e40p_apu_req_buffer;
    import cv32e40p_apu_core_pkg::*;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic                          apu_req_i;
    logic                          apu_gnt_o;
    logic [APU_NARGS_CPU*32-1:0]   apu_operands_i;
    logic [APU_WOP_CPU-1:0]        apu_op_i;
    logic [APU_NDSFLAGS_CPU-1:0]   apu_flags_i;
    logic                          apu_rvalid_o;
    logic [31:0]                   apu_result_o;
    logic [APU_NUSFLAGS_CPU-1:0]   apu_flags_o;
    logic                          fpu_req_o;
    logic                          fpu_gnt_i;
    logic [APU_NARGS_CPU*32-1:0]   fpu_operands_o;
    logic [APU_WOP_CPU-1:0]        fpu_op_o;
    logic [APU_NDSFLAGS_CPU-1:0]   fpu_flags_o;
    logic                          fpu_rvalid_i;
    logic [31:0]                   fpu_rdata_i;
    logic [APU_NUSFLAGS_CPU-1:0]   fpu_rflags_i;
    logic                          busy_o;

    int errors = 0;
    int checks = 0;

    cv32e40p_apu_req_buffer #(.REQ_DEPTH(2), .MAX_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
        .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
        .apu_rvalid_o(apu_rvalid_o), .apu_result_o(apu_result_o), .apu_flags_o(apu_flags_o),
        .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
        .fpu_rvalid_i(fpu_rvalid_i), .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        apu_req_i = 1'b0; apu_operands_i = '0; apu_op_i = '0; apu_flags_i = '0;
        fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b0; fpu_rdata_i = '0; fpu_rflags_i = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic send(input logic [5:0] op);
        apu_req_i      = 1'b1;
        apu_op_i       = op;
        apu_operands_i = {32'h1000_0000 + 32'(op), 32'h2000_0000 + 32'(op), 32'h3000_0000 + 32'(op)};
        apu_flags_i    = {9'h0, op};
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        tick();
        checks++; if (apu_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", apu_gnt_o); end
        checks++; if (fpu_req_o !== 1'b0) begin errors++; $display("FAIL rst_fpu_req: got %b want 0", fpu_req_o); end
        checks++; if (apu_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", apu_rvalid_o); end
        checks++; if ({apu_result_o, apu_flags_o} !== '0) begin errors++; $display("FAIL rst_result: got %h/%h want 0", apu_result_o, apu_flags_o); end
        checks++; if ({fpu_operands_o, fpu_op_o, fpu_flags_o} !== '0) begin errors++; $display("FAIL rst_payload: got %h want 0", fpu_op_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        checks++; if (dut.cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", dut.cnt); end
        rst_i = 1'b0;
        #1;
        checks++; if (apu_gnt_o !== 1'b1) begin errors++; $display("FAIL rst_gnt_after: got %b want 1", apu_gnt_o); end
    endtask

    task automatic test_single_op();
        do_reset();
        apu_req_i = 1'b1; apu_op_i = 6'h01; apu_operands_i = {32'd1, 32'd2, 32'd3}; apu_flags_i = 15'h0012;
        #1;
        checks++; if (apu_gnt_o !== 1'b1) begin errors++; $display("FAIL t1_gnt: got %b want 1", apu_gnt_o); end
        checks++; if (fpu_req_o !== 1'b0) begin errors++; $display("FAIL t1_no_bypass: got %b want 0", fpu_req_o); end
        tick();
        idle();
        #1;
        checks++; if (fpu_req_o !== 1'b1) begin errors++; $display("FAIL t1_fpu_req: got %b want 1", fpu_req_o); end
        checks++; if ({fpu_operands_o, fpu_op_o, fpu_flags_o} !== {32'd1, 32'd2, 32'd3, 6'h01, 15'h0012})
            begin errors++; $display("FAIL t1_payload: got %h op %h want 000000010000000200000003 op 01", fpu_operands_o, fpu_op_o); end
        fpu_gnt_i = 1'b1;
        tick();
        fpu_gnt_i = 1'b0;
        #1;
        checks++; if (dut.cnt !== 3'd1) begin errors++; $display("FAIL t1_cnt1: got %0d want 1", dut.cnt); end
        checks++; if (fpu_req_o !== 1'b0) begin errors++; $display("FAIL t1_req_drop: got %b want 0", fpu_req_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy_o); end
        fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'hDEADBEEF; fpu_rflags_i = 5'h03;
        checks++; if (apu_rvalid_o !== 1'b0) begin errors++; $display("FAIL t1_rvalid_early: got %b want 0", apu_rvalid_o); end
        tick();
        idle();
        #1;
        checks++; if (apu_rvalid_o !== 1'b1) begin errors++; $display("FAIL t1_rvalid: got %b want 1", apu_rvalid_o); end
        checks++; if (apu_result_o !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_result: got %h want deadbeef", apu_result_o); end
        checks++; if (apu_flags_o !== 5'h03) begin errors++; $display("FAIL t1_rflags: got %h want 03", apu_flags_o); end
        checks++; if (dut.cnt !== 3'd0) begin errors++; $display("FAIL t1_cnt0: got %0d want 0", dut.cnt); end
        tick();
        checks++; if (apu_rvalid_o !== 1'b0) begin errors++; $display("FAIL t1_pulse: got %b want 0", apu_rvalid_o); end
        checks++; if (apu_result_o !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_hold: got %h want deadbeef", apu_result_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t1_idle: got %b want 0", busy_o); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        send(6'h10); #1;
        checks++; if (apu_gnt_o !== 1'b1) begin errors++; $display("FAIL t2_gnt0: got %b want 1", apu_gnt_o); end
        tick();
        send(6'h11); #1;
        checks++; if (apu_gnt_o !== 1'b1) begin errors++; $display("FAIL t2_gnt1: got %b want 1", apu_gnt_o); end
        tick();
        send(6'h12); #1;
        checks++; if (apu_gnt_o !== 1'b0) begin errors++; $display("FAIL t2_full: got %b want 0", apu_gnt_o); end
        fpu_gnt_i = 1'b1; #1;
        checks++; if (apu_gnt_o !== 1'b0) begin errors++; $display("FAIL t2_full_pop: got %b want 0", apu_gnt_o); end
        checks++; if (fpu_op_o !== 6'h10) begin errors++; $display("FAIL t2_head0: got %h want 10", fpu_op_o); end
        tick();
        checks++; if (apu_gnt_o !== 1'b1) begin errors++; $display("FAIL t2_regnt: got %b want 1", apu_gnt_o); end
        checks++; if (fpu_op_o !== 6'h11) begin errors++; $display("FAIL t2_head1: got %h want 11", fpu_op_o); end
        tick();
        apu_req_i = 1'b0; #1;
        checks++; if ({fpu_req_o, fpu_op_o} !== {1'b1, 6'h12}) begin errors++; $display("FAIL t2_head2: got %b/%h want 1/12", fpu_req_o, fpu_op_o); end
        checks++; if (dut.cnt !== 3'd2) begin errors++; $display("FAIL t2_cnt2: got %0d want 2", dut.cnt); end
        tick();
        fpu_gnt_i = 1'b0; #1;
        checks++; if ({fpu_req_o, dut.cnt} !== {1'b0, 3'd3}) begin errors++; $display("FAIL t2_drained: got %b/%0d want 0/3", fpu_req_o, dut.cnt); end
        for (int i = 0; i < 3; i++) begin
            fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'hA0 + 32'(i);
            tick();
            checks++; if ({apu_rvalid_o, apu_result_o} !== {1'b1, 32'hA0 + 32'(i)})
                begin errors++; $display("FAIL t2_result%0d: got %b/%h want 1/%h", i, apu_rvalid_o, apu_result_o, 32'hA0 + 32'(i)); end
            checks++; if (dut.cnt !== 3'(2 - i)) begin errors++; $display("FAIL t2_cnt_dn%0d: got %0d want %0d", i, dut.cnt, 2 - i); end
        end
        idle();
    endtask

    task automatic test_inflight_cap();
        do_reset();
        fpu_gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(6'(6'h20 + i)); #1;
            checks++; if (apu_gnt_o !== 1'b1) begin errors++; $display("FAIL t3_gnt%0d: got %b want 1", i, apu_gnt_o); end
            checks++; if (fpu_req_o !== (i >= 1 && i <= 4))
                begin errors++; $display("FAIL t3_req%0d: got %b want %b", i, fpu_req_o, (i >= 1 && i <= 4)); end
            tick();
        end
        apu_req_i = 1'b0; #1;
        checks++; if ({fpu_req_o, dut.cnt, fpu_op_o} !== {1'b0, 3'd4, 6'h24})
            begin errors++; $display("FAIL t3_capped: got %b/%0d/%h want 0/4/24", fpu_req_o, dut.cnt, fpu_op_o); end
        checks++; if (apu_gnt_o !== 1'b0) begin errors++; $display("FAIL t3_full: got %b want 0", apu_gnt_o); end
        fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'h20; #1;
        checks++; if (fpu_req_o !== 1'b0) begin errors++; $display("FAIL t3_same_cycle: got %b want 0", fpu_req_o); end
        tick();
        fpu_rvalid_i = 1'b0; fpu_gnt_i = 1'b0; #1;
        checks++; if ({fpu_req_o, dut.cnt, apu_rvalid_o} !== {1'b1, 3'd3, 1'b1})
            begin errors++; $display("FAIL t3_reenable: got %b/%0d/%b want 1/3/1", fpu_req_o, dut.cnt, apu_rvalid_o); end
        idle();
    endtask

    task automatic test_grant_and_result();
        do_reset();
        fpu_gnt_i = 1'b1;
        send(6'h30); tick();
        send(6'h31); tick();
        apu_req_i = 1'b0; tick();
        send(6'h32); tick();
        apu_req_i = 1'b0; #1;
        checks++; if ({fpu_req_o, dut.cnt, fpu_op_o} !== {1'b1, 3'd2, 6'h32})
            begin errors++; $display("FAIL t4_pre: got %b/%0d/%h want 1/2/32", fpu_req_o, dut.cnt, fpu_op_o); end
        fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'h111;
        tick();
        fpu_gnt_i = 1'b0; fpu_rdata_i = 32'h222; #1;
        checks++; if ({dut.cnt, apu_rvalid_o, apu_result_o} !== {3'd2, 1'b1, 32'h111})
            begin errors++; $display("FAIL t4_same: got %0d/%b/%h want 2/1/111", dut.cnt, apu_rvalid_o, apu_result_o); end
        tick();
        fpu_rdata_i = 32'h333;
        checks++; if ({dut.cnt, apu_result_o} !== {3'd1, 32'h222}) begin errors++; $display("FAIL t4_r2: got %0d/%h want 1/222", dut.cnt, apu_result_o); end
        tick();
        fpu_rvalid_i = 1'b0;
        checks++; if ({dut.cnt, apu_result_o} !== {3'd0, 32'h333}) begin errors++; $display("FAIL t4_r3: got %0d/%h want 0/333", dut.cnt, apu_result_o); end
        idle();
    endtask

    task automatic test_reset_midop();
        do_reset();
        fpu_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin send(6'(6'h40 + i)); tick(); end
        fpu_gnt_i = 1'b0; send(6'h44); tick();
        apu_req_i = 1'b0; #1;
        checks++; if ({dut.cnt, apu_gnt_o, busy_o} !== {3'd3, 1'b0, 1'b1})
            begin errors++; $display("FAIL t5_pre: got %0d/%b/%b want 3/0/1", dut.cnt, apu_gnt_o, busy_o); end
        rst_i = 1'b1;
        tick();
        checks++; if ({apu_gnt_o, fpu_req_o, apu_rvalid_o, busy_o} !== 4'b0000)
            begin errors++; $display("FAIL t5_outs: got %b%b%b%b want 0000", apu_gnt_o, fpu_req_o, apu_rvalid_o, busy_o); end
        checks++; if ({dut.cnt, apu_result_o, apu_flags_o, fpu_operands_o, fpu_op_o, fpu_flags_o} !== '0)
            begin errors++; $display("FAIL t5_zero: got cnt %0d op %h want 0", dut.cnt, fpu_op_o); end
        rst_i = 1'b0; #1;
        checks++; if ({apu_gnt_o, fpu_req_o} !== 2'b10) begin errors++; $display("FAIL t5_empty: got %b%b want 10", apu_gnt_o, fpu_req_o); end
    endtask

    task automatic test_spurious();
        fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'hCAFEF00D; fpu_rflags_i = 5'h1F;
        tick();
        idle(); #1;
        checks++; if ({apu_rvalid_o, apu_result_o, apu_flags_o} !== {1'b1, 32'hCAFEF00D, 5'h1F})
            begin errors++; $display("FAIL t6_fwd: got %b/%h/%h want 1/cafef00d/1f", apu_rvalid_o, apu_result_o, apu_flags_o); end
        checks++; if (dut.cnt !== 3'd0) begin errors++; $display("FAIL t6_cnt: got %0d want 0", dut.cnt); end
        tick();
        checks++; if ({apu_rvalid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL t6_idle: got %b%b want 00", apu_rvalid_o, busy_o); end
    endtask

    task automatic test_random_stream();
        apu_req_t     req_q[$];
        logic [5:0]   out_q[$];
        apu_req_t     r;
        apu_req_t     g;
        logic         exp_gnt;
        logic         exp_req;
        logic         rv;
        logic [31:0]  exp_data;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r.op = 6'($urandom); r.operands = {$urandom, $urandom, $urandom}; r.flags = 15'($urandom);
            apu_req_i = 1'($urandom_range(0, 1));
            apu_op_i = r.op; apu_operands_i = r.operands; apu_flags_i = r.flags;
            fpu_gnt_i = ($urandom_range(0, 3) != 0);
            rv = (out_q.size() > 0) && ($urandom_range(0, 2) == 0);
            exp_data = rv ? (32'h5A5A_0000 | 32'(out_q[0])) : 32'h0;
            fpu_rvalid_i = rv; fpu_rdata_i = exp_data; fpu_rflags_i = 5'(c);
            #1;
            exp_gnt = (req_q.size() < 2);
            exp_req = (req_q.size() > 0) && (out_q.size() < 4);
            checks++; if (apu_gnt_o !== exp_gnt) begin errors++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, apu_gnt_o, exp_gnt); end
            checks++; if (fpu_req_o !== exp_req) begin errors++; $display("FAIL rnd_req@%0d: got %b want %b", c, fpu_req_o, exp_req); end
            if (exp_req) begin
                checks++; if ({fpu_operands_o, fpu_op_o, fpu_flags_o} !== req_q[0])
                    begin errors++; $display("FAIL rnd_payload@%0d: got op %h want %h", c, fpu_op_o, req_q[0].op); end
            end
            if (rv) void'(out_q.pop_front());
            if (exp_req && fpu_gnt_i) begin g = req_q.pop_front(); out_q.push_back(g.op); end
            if (apu_req_i && exp_gnt) req_q.push_back(r);
            tick();
            checks++; if (apu_rvalid_o !== rv) begin errors++; $display("FAIL rnd_rvalid@%0d: got %b want %b", c, apu_rvalid_o, rv); end
            if (rv) begin
                checks++; if (apu_result_o !== exp_data) begin errors++; $display("FAIL rnd_result@%0d: got %h want %h", c, apu_result_o, exp_data); end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        test_reset();
        test_single_op();
        test_fifo_full();
        test_inflight_cap();
        test_grant_and_result();
        test_reset_midop();
        test_spurious();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
